// File: rtl/cpu_pkg.sv
// Shared core definitions for the fetch stage.
// Holds the fetch FSM encoding and fetch constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

  localparam int unsigned WORD_INC = 4;

  localparam logic [31:0] NOP_INSTR =
    32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory request/grant/response port.
// Master is the fetch side, slave is the memory.
interface fetch_unit_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);

  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               gnt;
  logic               rvalid;
  logic [INSTR_W-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  gnt,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, imem handshake,
// redirect/stall handling and the IF/ID register.
import cpu_pkg::*;

module fetch_unit #(
  parameter int                 ADDR_W   = 32,
  parameter int                 INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  fetch_unit_if.master       imem,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               stall,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc_plus4
);

  fetch_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               drop_q, drop_d;
  logic [INSTR_W-1:0] buf_q, buf_d;
  logic               vld_q, vld_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc4_q, pc4_d;

  logic               req;
  logic               gnt_ok;
  logic [ADDR_W-1:0]  target;
  logic               unused_lsb;

  assign req       = (state_q == REQ) && rst_n;
  assign imem.req  = req;
  assign imem.addr = pc_q;
  assign gnt_ok    = req && imem.gnt;

  assign target     = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_lsb = ^redirect_pc[1:0];

  assign id_valid    = vld_q;
  assign id_instr    = instr_q;
  assign id_pc_plus4 = pc4_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    drop_d  = drop_q;
    buf_d   = buf_q;
    vld_d   = vld_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (redirect) begin
      vld_d   = 1'b0;
      pc_d    = target;
      state_d = REQ;
      drop_d  = 1'b0;
      // a request in flight must have its reply eaten
      if ((state_q == WAIT && !imem.rvalid) ||
          gnt_ok) begin
        drop_d  = 1'b1;
        state_d = WAIT;
      end
    end else begin
      if (!stall) vld_d = 1'b0;
      unique case (state_q)
        REQ: begin
          if (gnt_ok) begin
            pc_d    = pc_q + ADDR_W'(WORD_INC);
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (imem.rvalid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = REQ;
            end else if (!stall) begin
              vld_d   = 1'b1;
              instr_d = imem.rdata;
              pc4_d   = pc_q;
              state_d = REQ;
            end else begin
              buf_d   = imem.rdata;
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            vld_d   = 1'b1;
            instr_d = buf_q;
            pc4_d   = pc_q;
            state_d = REQ;
          end
        end
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
      drop_q  <= 1'b0;
      buf_q   <= '0;
      vld_q   <= 1'b0;
      instr_q <= '0;
      pc4_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      buf_q   <= buf_d;
      vld_q   <= vld_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: 32-bit core instance
// driven by a latency-programmable memory, plus a 16-bit wrap instance.
import cpu_pkg::*;

module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;

  logic        rst16;
  logic        id_valid16;
  logic [31:0] id_instr16;
  logic [15:0] id_pc4_16;
  logic        redirect16;
  logic [15:0] redirect_pc16;
  logic        stall16;

  int errors;
  int checks;
  int lat;
  int cnt;
  logic        pend;
  logic [31:0] paddr;

  fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) bus ();
  fetch_unit_if #(.ADDR_W(16), .INSTR_W(32)) bus16 ();

  fetch_unit #(
    .ADDR_W(32), .INSTR_W(32),
    .RESET_PC(32'h0040_0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .imem(bus),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc_plus4(id_pc_plus4)
  );

  fetch_unit #(
    .ADDR_W(16), .INSTR_W(32),
    .RESET_PC(16'hFFFC)
  ) dut16 (
    .clk(clk), .rst_n(rst16), .imem(bus16),
    .redirect(redirect16), .redirect_pc(redirect_pc16),
    .stall(stall16), .id_valid(id_valid16),
    .id_instr(id_instr16), .id_pc_plus4(id_pc4_16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h2008_0005;
    if (a == 32'h0040_0004) return 32'hAAAA_0001;
    return a ^ 32'h5A5A_0000;
  endfunction

  initial begin
    bus.gnt = 1'b0;
    bus.rvalid = 1'b0;
    bus.rdata = NOP_INSTR;
    pend = 1'b0;
    cnt = 0;
    paddr = '0;
    forever begin
      @(negedge clk);
      bus.rvalid = 1'b0;
      if (pend) begin
        if (cnt <= 1) begin
          bus.rvalid = 1'b1;
          bus.rdata = word_of(paddr);
          pend = 1'b0;
        end else begin
          cnt = cnt - 1;
        end
      end
      bus.gnt = bus.req && !pend && !bus.rvalid;
      if (bus.gnt) begin
        pend = 1'b1;
        cnt = lat;
        paddr = bus.addr;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) step();
    checks++;
    if (bus.req !== 1'b0) begin
      errors++;
      $display("FAIL rst_req: got %b want 0", bus.req);
    end
    checks++;
    if (id_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid: got %b want 0", id_valid);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (bus.req !== 1'b1 || bus.addr !== 32'h0040_0000) begin
      errors++;
      $display("FAIL first_req: got %b/%h want 1/00400000",
               bus.req, bus.addr);
    end
    step();
    checks++;
    if (bus.req !== 1'b0) begin
      errors++;
      $display("FAIL wait_req: got %b want 0", bus.req);
    end
    step();
    checks++;
    if (id_valid !== 1'b1 || id_instr !== 32'h2008_0005 ||
        id_pc_plus4 !== 32'h0040_0004) begin
      errors++;
      $display("FAIL first_ifid: got %b/%h/%h want 1/20080005/00400004",
               id_valid, id_instr, id_pc_plus4);
    end
    checks++;
    if (bus.req !== 1'b1 || bus.addr !== 32'h0040_0004) begin
      errors++;
      $display("FAIL second_req: got %b/%h want 1/00400004",
               bus.req, bus.addr);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.req !== 1'b0) begin
        errors++;
        $display("FAIL stall_req%0d: got %b want 0", i, bus.req);
      end
      checks++;
      if (id_valid !== 1'b1 || id_instr !== 32'h2008_0005 ||
          id_pc_plus4 !== 32'h0040_0004) begin
        errors++;
        $display("FAIL stall_hold%0d: got %b/%h/%h want 1/20080005/00400004",
                 i, id_valid, id_instr, id_pc_plus4);
      end
    end
    stall = 1'b0;
    lat = 2;
    step();
    checks++;
    if (id_valid !== 1'b1 || id_instr !== 32'hAAAA_0001 ||
        id_pc_plus4 !== 32'h0040_0008) begin
      errors++;
      $display("FAIL unstall_ifid: got %b/%h/%h want 1/aaaa0001/00400008",
               id_valid, id_instr, id_pc_plus4);
    end
    checks++;
    if (bus.req !== 1'b1 || bus.addr !== 32'h0040_0008) begin
      errors++;
      $display("FAIL unstall_req: got %b/%h want 1/00400008",
               bus.req, bus.addr);
    end
  endtask

  task automatic test_redirect_wait();
    step();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    step();
    redirect = 1'b0;
    checks++;
    if (id_valid !== 1'b0 || bus.req !== 1'b0) begin
      errors++;
      $display("FAIL redir_wait: got valid=%b req=%b want 0/0",
               id_valid, bus.req);
    end
    step();
    checks++;
    if (id_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_drop: got valid=%b want 0", id_valid);
    end
    checks++;
    if (bus.req !== 1'b1 || bus.addr !== 32'h0000_0100) begin
      errors++;
      $display("FAIL redir_addr: got %b/%h want 1/00000100",
               bus.req, bus.addr);
    end
  endtask

  task automatic test_redirect_rvalid_stall();
    lat = 1;
    step();
    step();
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    stall = 1'b1;
    step();
    redirect = 1'b0;
    stall = 1'b0;
    checks++;
    if (bus.req !== 1'b1 || bus.addr !== 32'h0000_0200 ||
        id_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_rv: got req=%b addr=%h valid=%b want 1/00000200/0",
               bus.req, bus.addr, id_valid);
    end
    step();
    lat = 3;
    step();
    checks++;
    if (id_valid !== 1'b1 || id_instr !== 32'h5A5A_0200 ||
        id_pc_plus4 !== 32'h0000_0204) begin
      errors++;
      $display("FAIL redir_target: got %b/%h/%h want 1/5a5a0200/00000204",
               id_valid, id_instr, id_pc_plus4);
    end
  endtask

  task automatic test_reset_mid();
    step();
    rst_n = 1'b0;
    step();
    checks++;
    if (bus.req !== 1'b0 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst: got req=%b valid=%b want 0/0",
               bus.req, id_valid);
    end
    rst_n = 1'b1;
    step();
    lat = 1;
    checks++;
    if (bus.req !== 1'b1 || bus.addr !== 32'h0040_0000 ||
        id_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_restart: got %b/%h/%b want 1/00400000/0",
               bus.req, bus.addr, id_valid);
    end
    step();
    checks++;
    if (id_valid !== 1'b0) begin
      errors++;
      $display("FAIL stale_ignored: got valid=%b want 0", id_valid);
    end
    step();
    step();
    checks++;
    if (id_valid !== 1'b1 || id_instr !== 32'h2008_0005 ||
        id_pc_plus4 !== 32'h0040_0004) begin
      errors++;
      $display("FAIL mid_fresh: got %b/%h/%h want 1/20080005/00400004",
               id_valid, id_instr, id_pc_plus4);
    end
  endtask

  task automatic test_wrap16();
    rst16 = 1'b1;
    step();
    checks++;
    if (bus16.req !== 1'b1 || bus16.addr !== 16'hFFFC) begin
      errors++;
      $display("FAIL wrap_pre: got %b/%h want 1/fffc",
               bus16.req, bus16.addr);
    end
    bus16.gnt = 1'b1;
    step();
    bus16.gnt = 1'b0;
    checks++;
    if (bus16.req !== 1'b0 || bus16.addr !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_addr: got %b/%h want 0/0000",
               bus16.req, bus16.addr);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    lat = 1;
    rst_n = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    stall = 1'b0;
    rst16 = 1'b0;
    redirect16 = 1'b0;
    redirect_pc16 = '0;
    stall16 = 1'b0;
    bus16.gnt = 1'b0;
    bus16.rvalid = 1'b0;
    bus16.rdata = NOP_INSTR;
    test_reset();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid_stall();
    test_reset_mid();
    test_wrap16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
